lampfpu_sqrt_sched: RTL

Two-port scheduler that shares the single iterative square-root unit between two requesters (e.g. two issue slots or a scalar pipe and a vector lane). It arbitrates round-robin and launches one operation at a time with a `doSqrt` pulse. It holds the operand fields stable for the whole operation, captures the unit's result on its `valid` pulse and returns it on a tagged response port with a valid/ready handshake. A watchdog aborts an operation that never completes.

---
 rtl/lampfpu_sqrt_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lampfpu_sqrt_sched.sv
// rtl/lampfpu_sqrt_sched.sv - two-port round-robin scheduler for the shared iterative sqrt unit
module lampfpu_sqrt_sched #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_invSqrt_i,
  input  logic [1:0]       req_sign_i,
  input  logic [15:0]      req_exp_i,
  input  logic [15:0]      req_mant_i,
  input  logic [7:0]       req_flags_i,
  output logic             doSqrt_o,
  output logic             invSqrt_o,
  output logic             signum_op_o,
  output logic [7:0]       extExp_op_o,
  output logic [7:0]       extMant_op_o,
  output logic             isInf_op_o,
  output logic             isZero_op_o,
  output logic             isSNAN_op_o,
  output logic             isQNAN_op_o,
  input  logic             sqrt_valid_i,
  input  logic             sqrt_s_i,
  input  logic [7:0]       sqrt_e_i,
  input  logic [6:0]       sqrt_f_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic             rsp_s_o,
  output logic [7:0]       rsp_e_o,
  output logic [6:0]       rsp_f_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last WAIT count before the watchdog gives up on the unit.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             r_op_inv;
  logic             r_op_sign;
  logic [7:0]       r_op_exp;
  logic [7:0]       r_op_mant;
  logic [3:0]       r_op_flags;

  logic             r_rsp_id;
  logic             r_rsp_s;
  logic [7:0]       r_rsp_e;
  logic [6:0]       r_rsp_f;
  logic             r_rsp_err;

  logic             w_req_any;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_launch;
  logic             w_capture;
  logic             w_abort;
  logic             w_handshake;

  // Arbitration: a lone requester wins outright, a tie goes to the round-robin pointer.
  always_comb begin
    w_req_any  = |req_valid_i;
    w_grant_id = (&req_valid_i) ? r_rr_ptr : req_valid_i[1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-state event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_launch    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (sqrt_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Watchdog counter: cleared at launch, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_launch) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Operand capture on grant; held until the next grant since the unit samples flags after launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_inv   <= 1'b0;
      r_op_sign  <= 1'b0;
      r_op_exp   <= '0;
      r_op_mant  <= '0;
      r_op_flags <= '0;
      r_rsp_id   <= 1'b0;
    end else if (w_accept) begin
      r_op_inv   <= w_grant_id ? req_invSqrt_i[1] : req_invSqrt_i[0];
      r_op_sign  <= w_grant_id ? req_sign_i[1]    : req_sign_i[0];
      r_op_exp   <= w_grant_id ? req_exp_i[15:8]  : req_exp_i[7:0];
      r_op_mant  <= w_grant_id ? req_mant_i[15:8] : req_mant_i[7:0];
      r_op_flags <= w_grant_id ? req_flags_i[7:4] : req_flags_i[3:0];
      r_rsp_id   <= w_grant_id;
    end
  end

  // Result capture: real result from the unit, or a quiet NaN with err on watchdog abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_s   <= 1'b0;
      r_rsp_e   <= '0;
      r_rsp_f   <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_capture) begin
      r_rsp_s   <= sqrt_s_i;
      r_rsp_e   <= sqrt_e_i;
      r_rsp_f   <= sqrt_f_i;
      r_rsp_err <= 1'b0;
    end else if (w_abort) begin
      r_rsp_s   <= 1'b0;
      r_rsp_e   <= 8'hFF;
      r_rsp_f   <= 7'h40;
      r_rsp_err <= 1'b1;
    end
  end

  // Fairness pointer: after serving a port, the other one wins the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_handshake) begin
      r_rr_ptr <= ~r_rsp_id;
    end
  end

  // Output mapping; ready is also gated by reset so nothing looks accepted while held in reset.
  always_comb begin
    req_ready_o  = (w_accept && rst) ? {w_grant_id, ~w_grant_id} : 2'b00;
    doSqrt_o     = w_launch;
    invSqrt_o    = r_op_inv;
    signum_op_o  = r_op_sign;
    extExp_op_o  = r_op_exp;
    extMant_op_o = r_op_mant;
    isInf_op_o   = r_op_flags[3];
    isZero_op_o  = r_op_flags[2];
    isSNAN_op_o  = r_op_flags[1];
    isQNAN_op_o  = r_op_flags[0];
    rsp_valid_o  = (r_state == S_RESP);
    rsp_id_o     = r_rsp_id;
    rsp_s_o      = r_rsp_s;
    rsp_e_o      = r_rsp_e;
    rsp_f_o      = r_rsp_f;
    rsp_err_o    = r_rsp_err;
    busy_o       = (r_state != S_IDLE);
  end

endmodule
